freq_counter_bcd: RTL and testbench

- Parametrised reciprocal-free frequency counter. Counts rising edges of an asynchronous input over a selectable gate window and presents the result as a DIGITS-wide BCD word for the seven-segment driver.
- Successor to the fixed 4-digit, fixed 1 s counter chain. Adds:
  - configurable digit count and clock rate
  - three gate ranges
  - input synchronisation
  - saturation/overflow
  - display hold
  - a result-valid strobe
- Sits between the board input pin and sevenseg; replaces the separate divider and BCD counter instances.

---
 rtl/freq_counter_bcd_if.sv | 12 +
 rtl/freq_counter_bcd.sv | 63 ++++++
 tb/tb_freq_counter_bcd.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/freq_counter_bcd_if.sv
// freq_counter_bcd_if: measurement inputs and latched BCD result of the frequency counter
interface freq_counter_bcd_if #(parameter int DIGITS = 4);
  logic sig_in;
  logic [1:0] gate_sel;
  logic hold;
  logic [4*DIGITS-1:0] bcd_out;
  logic [1:0] range;
  logic overflow;
  logic valid;
  modport master(output sig_in, gate_sel, hold, input bcd_out, range, overflow, valid);
  modport slave(input sig_in, gate_sel, hold, output bcd_out, range, overflow, valid);
endinterface

// File: rtl/freq_counter_bcd.sv
// freq_counter_bcd: counts sig_in rising edges over a selectable gate window into a saturating BCD word
module freq_counter_bcd #(
  parameter int CLK_HZ = 50000000,
  parameter int DIGITS = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic reset,
  freq_counter_bcd_if.slave bus
);
  localparam int GW = $clog2(10 * CLK_HZ);
  logic [SYNC_STAGES-1:0] sync;
  logic dly, run, sticky, rise, sat, tc;
  logic [1:0] rng, sel;
  logic [GW-1:0] gate_cnt, last;
  logic [4*DIGITS-1:0] acc, inc, acc_nx;
  logic [DIGITS:0] carry;
  assign carry[0] = 1'b1;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    logic [3:0] d;
    assign d = acc[4*i+:4];
    assign inc[4*i+:4] = carry[i] ? (d == 4'd9 ? 4'd0 : d + 4'd1) : d;
    assign carry[i+1] = carry[i] & (d == 4'd9);
  end
  always_comb begin
    sel = bus.gate_sel == 2'd3 ? 2'd0 : bus.gate_sel;
    last = rng == 2'd1 ? GW'(CLK_HZ / 10 - 1) : rng == 2'd2 ? GW'(10 * CLK_HZ - 1) : GW'(CLK_HZ - 1);
    tc = run & (gate_cnt == last);
    rise = sync[SYNC_STAGES-1] & ~dly;
    sat = rise & carry[DIGITS];
    acc_nx = rise & ~carry[DIGITS] ? inc : acc;
  end
  // run holds the gate counter for one cycle so the window starts on the first edge out of reset
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      dly <= 1'b0;
      run <= 1'b0;
      gate_cnt <= '0;
      rng <= sel;
      acc <= '0;
      sticky <= 1'b0;
      bus.bcd_out <= '0;
      bus.range <= 2'd0;
      bus.overflow <= 1'b0;
      bus.valid <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], bus.sig_in};
      dly <= sync[SYNC_STAGES-1];
      run <= 1'b1;
      gate_cnt <= (!run || tc) ? '0 : gate_cnt + GW'(1);
      rng <= tc ? sel : rng;
      acc <= tc ? '0 : acc_nx;
      sticky <= ~tc & (sticky | sat);
      bus.valid <= tc & ~bus.hold;
      if (tc && !bus.hold) begin
        bus.bcd_out <= acc_nx;
        bus.overflow <= sticky | sat;
        bus.range <= rng;
      end
    end
  end
endmodule

// File: tb/tb_freq_counter_bcd.sv
// tb_freq_counter_bcd: directed checks of window timing, BCD counts, saturation, hold and reset
module tb_freq_counter_bcd;
  logic clk = 1'b0, reset = 1'b1, sig = 1'b0, man = 1'b0, hold = 1'b0;
  logic [1:0] gate_sel = 2'd0;
  int per = 0, ph = 0, checks = 0, errors = 0, n = 0, hits = 0;
  always #5 clk = ~clk;
  freq_counter_bcd_if #(.DIGITS(4)) b4();
  freq_counter_bcd_if #(.DIGITS(2)) b2();
  assign b4.sig_in = sig;
  assign b4.gate_sel = gate_sel;
  assign b4.hold = hold;
  assign b2.sig_in = sig;
  assign b2.gate_sel = gate_sel;
  assign b2.hold = hold;
  freq_counter_bcd #(.CLK_HZ(100), .DIGITS(4), .SYNC_STAGES(2)) dut4 (.clk(clk), .reset(reset), .bus(b4.slave));
  freq_counter_bcd #(.CLK_HZ(100), .DIGITS(2), .SYNC_STAGES(2)) dut2 (.clk(clk), .reset(reset), .bus(b2.slave));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // advance to the next falling edge and step the sig_in pattern (periodic, or man when per is 0)
  task automatic tick();
    @(negedge clk);
    if (per == 0) begin
      ph = 0;
      sig = man;
    end else begin
      sig = ph < per / 2;
      ph = (ph + 1 >= per) ? 0 : ph + 1;
    end
  endtask
  task automatic wait_valid(input int lim, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!b4.valid && cyc <= lim);
  endtask
  initial begin
    repeat (3) tick();
    chk("rst_bcd", b4.bcd_out, 0);
    chk("rst_range", b4.range, 0);
    chk("rst_ovf", b4.overflow, 0);
    chk("rst_valid", b4.valid, 0);
    reset = 1'b0;
    per = 10;
    wait_valid(120, n);
    chk("t1_first_lat", n, 101);
    chk("t1_first_bcd", b4.bcd_out == 16'h0009 || b4.bcd_out == 16'h0010, 1);
    tick();
    chk("t1_pulse", b4.valid, 0);
    wait_valid(110, n);
    chk("t1_period", n + 1, 100);
    chk("t1_bcd", b4.bcd_out, 16'h0010);
    chk("t1_ovf", b4.overflow, 0);
    chk("t1_range", b4.range, 0);
    gate_sel = 2'd2;
    per = 2;
    wait_valid(110, n);
    chk("t2_close_len", n, 100);
    chk("t2_close_rng", b4.range, 0);
    wait_valid(1010, n);
    chk("t2_len", n, 1000);
    chk("t2_bcd4", b4.bcd_out, 16'h0500);
    chk("t2_rng4", b4.range, 2);
    chk("t2_ovf4", b4.overflow, 0);
    chk("t2_valid2", b2.valid, 1);
    chk("t2_bcd2", b2.bcd_out, 8'h99);
    chk("t2_ovf2", b2.overflow, 1);
    gate_sel = 2'd0;
    per = 10;
    wait_valid(1010, n);
    chk("t2_mix_len", n, 1000);
    chk("t2_mix_rng", b4.range, 2);
    wait_valid(110, n);
    chk("t2_clr_len", n, 100);
    chk("t2_clr_bcd2", b2.bcd_out, 8'h10);
    chk("t2_clr_ovf2", b2.overflow, 0);
    chk("t2_clr_bcd4", b4.bcd_out, 16'h0010);
    per = 5;
    wait_valid(110, n);
    repeat (50) tick();
    gate_sel = 2'd1;
    wait_valid(60, n);
    chk("t3_len", n + 50, 100);
    chk("t3_bcd", b4.bcd_out, 16'h0020);
    chk("t3_rng", b4.range, 0);
    for (int i = 0; i < 2; i++) begin
      wait_valid(20, n);
      chk("t3_short_len", n, 10);
      chk("t3_short_bcd", b4.bcd_out, 16'h0002);
      chk("t3_short_rng", b4.range, 1);
    end
    gate_sel = 2'd0;
    per = 10;
    wait_valid(20, n);
    chk("t4_pre_len", n, 10);
    wait_valid(110, n);
    chk("t4_pre_bcd", b4.bcd_out, 16'h0010);
    hold = 1'b1;
    per = 4;
    hits = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      hits += int'(b4.valid);
    end
    chk("t4_no_valid", hits, 0);
    chk("t4_hold_bcd", b4.bcd_out, 16'h0010);
    chk("t4_hold_rng", b4.range, 0);
    hold = 1'b0;
    wait_valid(110, n);
    chk("t4_rel_len", n, 100);
    chk("t4_rel_bcd", b4.bcd_out, 16'h0025);
    repeat (59) tick();
    reset = 1'b1;
    tick();
    chk("t5_bcd", b4.bcd_out, 0);
    chk("t5_range", b4.range, 0);
    chk("t5_ovf", b4.overflow, 0);
    chk("t5_valid", b4.valid, 0);
    reset = 1'b0;
    wait_valid(120, n);
    chk("t5_lat", n, 101);
    chk("t5_rng", b4.range, 0);
    per = 0;
    man = 1'b0;
    wait_valid(110, n);
    wait_valid(110, n);
    chk("t6_quiet", b4.bcd_out, 0);
    for (int i = 1; i <= 300; i++) begin
      man = (i == 10 || i == 11 || i == 97 || i == 99 || i == 198);
      tick();
      if (i % 100 == 0) begin
        chk("t6_valid", b4.valid, 1);
        chk("t6_bcd", b4.bcd_out, i == 100 ? 2 : 1);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
